// File: rtl/intrarecon_luma4x4_if.sv
`default_nettype none
// ============================================================================
// intrarecon_luma4x4_if : macroblock setup, mode/residual input and recon output
// Revision 1.0
// ============================================================================
interface intrarecon_luma4x4_if #(
  parameter int MB_NUMBER_BITS = 12
);
  logic                      start;
  logic [MB_NUMBER_BITS:0]   mbnumber;
  logic [19:0][7:0]          top_in;
  logic [15:0][7:0]          left_in;
  logic [7:0]                corner_in;
  logic                      in_valid;
  logic                      in_ready;
  logic [2:0]                mode;
  logic [15:0][7:0]          res;
  logic                      out_valid;
  logic                      out_ready;
  logic [15:0][7:0]          recon;
  logic [3:0]                out_blkidx;
  logic [MB_NUMBER_BITS:0]   out_mbnumber;
  logic                      mb_done;
  logic                      busy;

  modport master (
    output start, mbnumber, top_in, left_in, corner_in, in_valid, mode, res, out_ready,
    input  in_ready, out_valid, recon, out_blkidx, out_mbnumber, mb_done, busy
  );

  modport slave (
    input  start, mbnumber, top_in, left_in, corner_in, in_valid, mode, res, out_ready,
    output in_ready, out_valid, recon, out_blkidx, out_mbnumber, mb_done, busy
  );
endinterface
`default_nettype wire

// File: rtl/intrarecon_luma4x4.sv
`default_nettype none
// ============================================================================
// intrarecon_luma4x4 : sequential 4x4 luma intra reconstruction of one 16x16 MB
// Revision 1.0
// ============================================================================
module intrarecon_luma4x4 #(
  parameter int MB_NUMBER_BITS = 12
) (
  input  wire logic            clk,
  input  wire logic            reset,
  intrarecon_luma4x4_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    PRED   = 3'd2,
    RECON  = 3'd3,
    OUT    = 3'd4
  } state_t;

  // Edge array e[0..12] = L K J I M A B C D E F G H. Each predicted pixel is
  // copy(e[b]), avg2(e[a],e[b]) or filt3(e[a],e[b],e[c]); this resolves the taps.
  function automatic logic [13:0] tap(input int m, input int x, input int y);
    int k, a, b, c, z;
    k = 0; a = 0; b = 0; c = 0; z = 0;
    case (m)
      0: b = 5 + x;
      1: b = 3 - y;
      2: begin
        a = 5 + x + y / 2; b = a + 1; c = a + 2;
        k = (y % 2 == 0) ? 1 : 2;
      end
      3: begin
        z = 2 * x - y;
        if (z >= 0 && z % 2 == 0) begin k = 1; a = 4 + x - y / 2; b = a + 1; end
        else if (z > 0)           begin k = 2; b = 4 + x - y / 2; a = b - 1; c = b + 1; end
        else if (z == -1)         begin k = 2; a = 3; b = 4; c = 5; end
        else                      begin k = 2; b = 5 - y; a = b - 1; c = b + 1; end
      end
      4: begin
        z = x + 2 * y;
        if (z == 0 || z == 2 || z == 4) begin k = 1; a = 3 - (y + x / 2); b = a - 1; end
        else if (z == 1 || z == 3)      begin k = 2; a = 3 - (y + x / 2); b = a - 1; c = a - 2; end
        else if (z == 5)                begin k = 2; a = 1; b = 0; c = 0; end
        else                            begin k = 0; b = 0; end
      end
      5: begin
        z = 2 * y - x;
        if (z >= 0 && z % 2 == 0) begin k = 1; a = 4 - y + x / 2; b = a - 1; end
        else if (z > 0)           begin k = 2; b = 4 - y + x / 2; a = b - 1; c = b + 1; end
        else if (z == -1)         begin k = 2; a = 3; b = 4; c = 5; end
        else                      begin k = 2; b = 3 + x; a = b - 1; c = b + 1; end
      end
      6: begin
        k = 2;
        if (x == 3 && y == 3) begin a = 11; b = 12; c = 12; end
        else                  begin a = 5 + x + y; b = a + 1; c = a + 2; end
      end
      default: begin k = 2; b = 4 + x - y; a = b - 1; c = b + 1; end
    endcase
    return {k[1:0], a[3:0], b[3:0], c[3:0]};
  endfunction

  function automatic logic [7:0] avg2(input logic [7:0] a, input logic [7:0] b);
    return 8'(({1'b0, a} + {1'b0, b} + 9'd1) >> 1);
  endfunction

  function automatic logic [7:0] filt3(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c);
    return 8'(({2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c} + 10'd2) >> 2);
  endfunction

  function automatic logic [7:0] clip_add(input logic [7:0] p, input logic [7:0] r);
    logic [9:0] s;
    s = {2'b00, p} + {{2{r[7]}}, r};
    if (s[9])      return 8'd0;
    else if (s[8]) return 8'd255;
    else           return s[7:0];
  endfunction

  state_t                  state, state_nxt;
  logic [3:0]              idx;
  logic [1:0]              row, col;
  logic [3:0]              up_r, left_c;
  logic                    accept, out_hs;
  logic [7:0]              top_q  [20];
  logic [7:0]              left_q [16];
  logic [7:0]              corner_q;
  logic [MB_NUMBER_BITS:0] mbnum_q;
  logic [2:0]              mode_q;
  logic [15:0][7:0]        res_q;
  logic [7:0]              pred_c [16];
  logic [7:0]              pred_q [16];
  logic [15:0][7:0]        recon_q;
  logic                    mb_done_q;
  logic [7:0]              mbuf [16][16];
  logic [7:0]              edge_px [13];
  logic [7:0]              d_px;

  assign row    = idx[3:2];
  assign col    = idx[1:0];
  assign up_r   = {row - 2'd1, 2'd3};
  assign left_c = {col - 2'd1, 2'd3};
  assign accept = (state == ACCEPT) && bus.in_valid;
  assign out_hs = (state == OUT) && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start)     state_nxt = ACCEPT;
      ACCEPT:  if (bus.in_valid)  state_nxt = PRED;
      PRED:                       state_nxt = RECON;
      RECON:                      state_nxt = OUT;
      OUT:     if (bus.out_ready) state_nxt = (idx == 4'd15) ? IDLE : ACCEPT;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= 4'd0;
      recon_q   <= '0;
      mbnum_q   <= '0;
      mb_done_q <= 1'b0;
    end else begin
      mb_done_q <= 1'b0;
      if (state == IDLE && bus.start) begin
        idx     <= 4'd0;
        mbnum_q <= bus.mbnumber;
      end
      if (state == RECON) begin
        for (int k = 0; k < 16; k++) recon_q[k] <= clip_add(pred_q[k], res_q[k]);
      end
      if (out_hs) begin
        idx <= idx + 4'd1;
        if (idx == 4'd15) mb_done_q <= 1'b1;
      end
    end
  end

  // Datapath storage needs no reset: every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      for (int k = 0; k < 20; k++) top_q[k]  <= bus.top_in[k];
      for (int k = 0; k < 16; k++) left_q[k] <= bus.left_in[k];
      corner_q <= bus.corner_in;
    end
    if (accept) begin
      mode_q <= bus.mode;
      res_q  <= bus.res;
    end
    if (state == PRED) begin
      for (int k = 0; k < 16; k++) pred_q[k] <= pred_c[k];
    end
    if (out_hs) begin
      for (int j = 0; j < 4; j++)
        for (int i = 0; i < 4; i++)
          mbuf[{row, 2'(j)}][{col, 2'(i)}] <= recon_q[4 * j + i];
    end
  end

  always_comb begin
    for (int k = 0; k < 13; k++) edge_px[k] = 8'd0;
    d_px = (row == 2'd0) ? top_q[{col, 2'd3}] : mbuf[up_r][{col, 2'd3}];
    for (int i = 0; i < 4; i++) begin
      edge_px[5 + i] = (row == 2'd0) ? top_q[{col, 2'(i)}] : mbuf[up_r][{col, 2'(i)}];
      if (row == 2'd0)      edge_px[9 + i] = top_q[5'({col, 2'(i)}) + 5'd4];
      else if (col != 2'd3) edge_px[9 + i] = mbuf[up_r][{col + 2'd1, 2'(i)}];
      else                  edge_px[9 + i] = d_px;
      edge_px[3 - i] = (col == 2'd0) ? left_q[{row, 2'(i)}] : mbuf[{row, 2'(i)}][left_c];
    end
    if (row == 2'd0 && col == 2'd0) edge_px[4] = corner_q;
    else if (row == 2'd0)           edge_px[4] = top_q[{col - 2'd1, 2'd3}];
    else if (col == 2'd0)           edge_px[4] = left_q[{row - 2'd1, 2'd3}];
    else                            edge_px[4] = mbuf[up_r][left_c];
  end

  for (genvar p = 0; p < 16; p++) begin : g_pix
    logic [7:0] cand [8];
    for (genvar m = 0; m < 8; m++) begin : g_mode
      localparam logic [13:0] TAP  = tap(m, p % 4, p / 4);
      localparam int          KIND = int'(TAP[13:12]);
      localparam int          I0   = int'(TAP[11:8]);
      localparam int          I1   = int'(TAP[7:4]);
      localparam int          I2   = int'(TAP[3:0]);
      assign cand[m] = (KIND == 0) ? edge_px[I1] :
                       (KIND == 1) ? avg2(edge_px[I0], edge_px[I1]) :
                                     filt3(edge_px[I0], edge_px[I1], edge_px[I2]);
    end
    assign pred_c[p] = cand[mode_q];
  end

  assign bus.in_ready     = (state == ACCEPT);
  assign bus.out_valid    = (state == OUT);
  assign bus.recon        = recon_q;
  assign bus.out_blkidx   = idx;
  assign bus.out_mbnumber = mbnum_q;
  assign bus.mb_done      = mb_done_q;
  assign bus.busy         = (state != IDLE);

endmodule
`default_nettype wire
